// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the memory-access stage (master) and the responder (slave).
interface data_mem_responder_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             mem_wr;
  logic [31:0]      mem_w_addr;
  logic [31:0]      mem_w_data;
  logic             mem_rd;
  logic [31:0]      mem_r_addr;
  logic [31:0]      mem_r_data;
  logic             mem_r_valid;
  logic             wr_stall;
  logic             fault;
  logic [CNT_W-1:0] buf_count;

  modport master (
    output mem_wr, mem_w_addr, mem_w_data, mem_rd, mem_r_addr,
    input  mem_r_data, mem_r_valid, wr_stall, fault, buf_count
  );

  modport slave (
    input  mem_wr, mem_w_addr, mem_w_data, mem_rd, mem_r_addr,
    output mem_r_data, mem_r_valid, wr_stall, fault, buf_count
  );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder: posted-write buffer draining into a word RAM,
// 1-cycle loads with youngest-store forwarding, bad-access fault pulse.
module data_mem_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned RAM_WORDS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [31:0]       data;
  } wb_entry_t;

  logic [31:0] ram_q [RAM_WORDS];
  wb_entry_t   buf_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      r_data_q, r_data_d;
  logic             r_valid_q, r_valid_d;
  logic             fault_q, fault_d;

  logic [ADDR_W-1:0] w_idx, r_idx;
  logic              w_bad, r_bad;
  logic              stall, push, pop;
  logic              fwd_hit;
  logic [31:0]       fwd_data;
  logic [PTR_W-1:0]  slot;

  // Address decode: word index plus misalignment / out-of-range detection
  always_comb begin
    w_idx = bus.mem_w_addr[ADDR_W+1:2];
    r_idx = bus.mem_r_addr[ADDR_W+1:2];
    w_bad = (bus.mem_w_addr[1:0] != 2'b00) || (|bus.mem_w_addr[31:ADDR_W+2]);
    r_bad = (bus.mem_r_addr[1:0] != 2'b00) || (|bus.mem_r_addr[31:ADDR_W+2]);
  end

  // Stall looks at the registered count only; a same-cycle drain does not lift it
  assign stall = (count_q == CNT_W'(DEPTH));
  assign push  = bus.mem_wr && !stall && !w_bad;
  assign pop   = !bus.mem_rd && (count_q != '0);

  // Youngest matching buffered store; later (younger) slots overwrite earlier hits
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (buf_q[slot].idx == r_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_q[slot].data;
      end
    end
  end

  // Next-state for pointers, count, and the registered load/fault outputs
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    fault_d   = (bus.mem_rd && r_bad) || (bus.mem_wr && w_bad);

    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (bus.mem_rd) begin
      r_valid_d = 1'b1;
      if (r_bad)        r_data_d = '0;
      else if (fwd_hit) r_data_d = fwd_data;
      else              r_data_d = ram_q[r_idx];
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      fault_q   <= fault_d;
    end
  end

  // Write-buffer payload storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push) buf_q[tail_q] <= '{idx: w_idx, data: bus.mem_w_data};
  end

  // Single-ported RAM written only by the drain, never while a load is in flight
  always_ff @(posedge clk) begin
    if (pop) ram_q[buf_q[head_q].idx] <= buf_q[head_q].data;
  end

  assign bus.mem_r_data  = r_data_q;
  assign bus.mem_r_valid = r_valid_q;
  assign bus.wr_stall    = stall;
  assign bus.fault       = fault_q;
  assign bus.buf_count   = count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (ADDR_W=10, DEPTH=4).
module tb_data_mem_responder;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  data_mem_responder_if #(.DEPTH(4)) bus ();

  data_mem_responder #(.ADDR_W(10), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                       input logic rd, input logic [31:0] ra);
    bus.mem_wr     = wr;
    bus.mem_w_addr = wa;
    bus.mem_w_data = wd;
    bus.mem_rd     = rd;
    bus.mem_r_addr = ra;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic load_chk(input string tag, input logic [31:0] ra, input logic [31:0] exp);
    drive(1'b0, 32'h0, 32'h0, 1'b1, ra);
    tick();
    chk({tag, "_valid"}, 32'(bus.mem_r_valid), 32'd1);
    chk(tag, bus.mem_r_data, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rdata", bus.mem_r_data, 32'h0);
    chk("rst_rvalid", 32'(bus.mem_r_valid), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_count", 32'(bus.buf_count), 32'd0);
    chk("rst_stall", 32'(bus.wr_stall), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Store then forwarded load, then load from RAM after drain
    drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    tick();
    chk("t1_count1", 32'(bus.buf_count), 32'd1);
    chk("t1_novalid", 32'(bus.mem_r_valid), 32'd0);
    load_chk("t1_fwd", 32'h10, 32'hDEADBEEF);
    chk("t1_count_held", 32'(bus.buf_count), 32'd1);
    idle();
    tick();
    chk("t1_valid_drop", 32'(bus.mem_r_valid), 32'd0);
    chk("t1_data_hold", bus.mem_r_data, 32'hDEADBEEF);
    chk("t1_drained", 32'(bus.buf_count), 32'd0);
    tick();
    load_chk("t1_ram", 32'h10, 32'hDEADBEEF);

    // Fill buffer while loads starve the drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 32'h100);
      chk("t2_nostall", 32'(bus.wr_stall), 32'd0);
      tick();
    end
    chk("t2_full", 32'(bus.buf_count), 32'd4);
    chk("t2_stall", 32'(bus.wr_stall), 32'd1);
    drive(1'b1, 32'h210, 32'hA4, 1'b1, 32'h100);
    tick();
    chk("t2_dropped", 32'(bus.buf_count), 32'd4);
    drive(1'b1, 32'h210, 32'hA4, 1'b0, 32'h0);
    chk("t2_stall_keep", 32'(bus.wr_stall), 32'd1);
    tick();
    chk("t2_drain1", 32'(bus.buf_count), 32'd3);
    chk("t2_unstall", 32'(bus.wr_stall), 32'd0);
    tick();
    chk("t2_pushpop", 32'(bus.buf_count), 32'd3);
    idle();
    tick();
    chk("t2_drain2", 32'(bus.buf_count), 32'd2);
    tick();
    chk("t2_drain3", 32'(bus.buf_count), 32'd1);
    tick();
    chk("t2_drain4", 32'(bus.buf_count), 32'd0);
    load_chk("t2_ram_a4", 32'h210, 32'hA4);
    load_chk("t2_ram_a0", 32'h200, 32'hA0);
    load_chk("t2_ram_a3", 32'h20C, 32'hA3);

    // Youngest matching store wins while drain is starved
    drive(1'b1, 32'h20, 32'h1, 1'b1, 32'h100);
    tick();
    drive(1'b1, 32'h20, 32'h2, 1'b1, 32'h100);
    tick();
    chk("t3_count", 32'(bus.buf_count), 32'd2);
    load_chk("t3_youngest", 32'h20, 32'h2);
    idle();
    tick();
    tick();
    chk("t3_drained", 32'(bus.buf_count), 32'd0);
    load_chk("t3_ram_idx8", 32'h20, 32'h2);

    // Same-cycle load and store: load sees old RAM value
    drive(1'b1, 32'h40, 32'h55, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    chk("t4_prefill", 32'(bus.buf_count), 32'd0);
    drive(1'b1, 32'h40, 32'h66, 1'b1, 32'h40);
    tick();
    chk("t4_old", bus.mem_r_data, 32'h55);
    chk("t4_pushed", 32'(bus.buf_count), 32'd1);
    load_chk("t4_new", 32'h40, 32'h66);
    idle();
    tick();

    // Bad accesses
    drive(1'b1, 32'h3, 32'h77, 1'b0, 32'h0);
    tick();
    chk("t5_wfault", 32'(bus.fault), 32'd1);
    chk("t5_wcount", 32'(bus.buf_count), 32'd0);
    idle();
    tick();
    chk("t5_wfault_end", 32'(bus.fault), 32'd0);
    load_chk("t5_rdata0", 32'h0001_0000, 32'h0);
    chk("t5_rfault", 32'(bus.fault), 32'd1);
    idle();
    tick();
    chk("t5_rfault_end", 32'(bus.fault), 32'd0);
    drive(1'b1, 32'h0000_2000, 32'h99, 1'b1, 32'h2);
    tick();
    chk("t5_both_fault", 32'(bus.fault), 32'd1);
    chk("t5_both_count", 32'(bus.buf_count), 32'd0);
    idle();
    tick();
    chk("t5_both_end", 32'(bus.fault), 32'd0);

    // Reset mid-drain discards buffered stores
    drive(1'b1, 32'h64, 32'hC1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h68, 32'hC2, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    tick();
    chk("t6_prefill", 32'(bus.buf_count), 32'd0);
    drive(1'b1, 32'h60, 32'h11, 1'b1, 32'h10);
    tick();
    drive(1'b1, 32'h64, 32'h22, 1'b1, 32'h10);
    tick();
    drive(1'b1, 32'h68, 32'h33, 1'b1, 32'h10);
    tick();
    chk("t6_count3", 32'(bus.buf_count), 32'd3);
    chk("t6_rdata_pre", bus.mem_r_data, 32'hDEADBEEF);
    idle();
    tick();
    chk("t6_mid_drain", 32'(bus.buf_count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rdata", bus.mem_r_data, 32'h0);
    chk("t6_rst_count", 32'(bus.buf_count), 32'd0);
    chk("t6_rst_stall", 32'(bus.wr_stall), 32'd0);
    chk("t6_rst_fault", 32'(bus.fault), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_post_count", 32'(bus.buf_count), 32'd0);
    load_chk("t6_ram_60", 32'h60, 32'h11);
    load_chk("t6_ram_64", 32'h64, 32'hC1);
    load_chk("t6_ram_68", 32'h68, 32'hC2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
